// File: rtl/msdf_otf_converter.sv
// On-the-fly conversion of an MSDF radix-2 signed-digit stream into a two's complement
// fraction word. Q/QM pair avoids any carry-propagate adder.
module msdf_otf_converter #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_first,
    input  logic [1:0]   in_digit,
    output logic         busy,
    output logic         done,
    output logic [N:0]   result
);

    localparam int unsigned W = N + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]    state, state_n;
    logic [CW-1:0] count, count_n;
    logic [W-1:0]  q, q_n;
    logic [W-1:0]  qm, qm_n;
    logic          done_n;
    logic [W-1:0]  result_n;

    logic          dig_pos, dig_neg;
    logic          restart, accept;
    logic [W-1:0]  q_base, qm_base;
    logic [W-1:0]  q_sh, qm_sh;
    logic [W-1:0]  q_upd, qm_upd;
    logic [CW-1:0] cnt_upd;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            q      <= '0;
            qm     <= '1;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            q      <= q_n;
            qm     <= qm_n;
            done   <= done_n;
            result <= result_n;
        end
    end

    // Next-state: a first digit always restarts from the (0, -1) seed
    always_comb begin
        state_n  = state;
        count_n  = count;
        q_n      = q;
        qm_n     = qm;
        done_n   = 1'b0;
        result_n = result;

        dig_pos  = in_digit[1] & ~in_digit[0];
        dig_neg  = ~in_digit[1] & in_digit[0];

        restart  = in_first || (state == IDLE);
        accept   = in_valid && (in_first || (state == ACCUM));

        q_base   = restart ? '0 : q;
        qm_base  = restart ? '1 : qm;
        q_sh     = q_base << 1;
        qm_sh    = qm_base << 1;

        if (dig_pos) begin
            q_upd  = q_sh | W'(1);
            qm_upd = q_sh;
        end else if (dig_neg) begin
            q_upd  = qm_sh | W'(1);
            qm_upd = qm_sh;
        end else begin
            q_upd  = q_sh;
            qm_upd = qm_sh | W'(1);
        end

        cnt_upd = in_first ? CW'(1) : (count + CW'(1));

        if (accept) begin
            if (cnt_upd == CW'(N)) begin
                result_n = q_upd;
                done_n   = 1'b1;
                state_n  = IDLE;
                count_n  = '0;
                q_n      = '0;
                qm_n     = '1;
            end else begin
                state_n  = ACCUM;
                count_n  = cnt_upd;
                q_n      = q_upd;
                qm_n     = qm_upd;
            end
        end
    end

    assign busy = (state == ACCUM);

endmodule
